// File: rtl/seq_lock_pkg.sv
// seq_lock_pkg: shared state type, default parameters and helpers for the sequence lock
package seq_lock_pkg;
  typedef enum logic [1:0] {IDLE, OPEN, LOCKOUT} state_e;
  localparam int SEQ_LEN_DEF = 4;
  localparam int SYM_W_DEF = 2;
  localparam logic [7:0] PATTERN_DEF = 8'h36;
  localparam int MAX_FAILS_DEF = 3;
  localparam int LOCK_CYCLES_DEF = 16;
  localparam int PAT_MAX_W = 64;
  localparam int SYM_MAX_W = 8;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic logic [SYM_MAX_W-1:0] sym_at(input logic [PAT_MAX_W-1:0] pattern, input int i, input int w);
    return SYM_MAX_W'(pattern >> (i * w));
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable down-counter that saturates at zero and flags done
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] cnt_q, cnt_d;
  assign done = (cnt_q == '0);
  always_comb cnt_d = load ? load_val : (en && !done) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/seq_lock_moore.sv
// seq_lock_moore: programmable Moore sequence lock with failure counting and timed lockout
module seq_lock_moore
  import seq_lock_pkg::*;
#(
  parameter int SEQ_LEN = SEQ_LEN_DEF,
  parameter int SYM_W = SYM_W_DEF,
  parameter logic [SEQ_LEN*SYM_W-1:0] PATTERN = PATTERN_DEF,
  parameter int MAX_FAILS = MAX_FAILS_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sym_valid,
  input  logic [SYM_W-1:0]              sym,
  input  logic                          cfg_load,
  input  logic [SEQ_LEN*SYM_W-1:0]      cfg_pattern,
  output logic                          P1,
  output logic                          P2,
  output logic [$clog2(SEQ_LEN+1)-1:0]  progress
);
  localparam int PAT_W = SEQ_LEN * SYM_W;
  localparam int IDX_W = cw(SEQ_LEN);
  localparam int FAIL_W = cw(MAX_FAILS + 1);
  localparam int TMR_W = cw(LOCK_CYCLES);
  localparam int PROG_W = $clog2(SEQ_LEN + 1);
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [FAIL_W-1:0]  fail_q, fail_d, fail_inc;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [SYM_W-1:0]   cur_sym, first_sym;
  logic               tmr_load, tmr_done;
  assign cur_sym = SYM_W'(sym_at(PAT_MAX_W'(pat_q), int'(idx_q), SYM_W));
  assign first_sym = SYM_W'(sym_at(PAT_MAX_W'(pat_q), 0, SYM_W));
  assign fail_inc = fail_q + FAIL_W'(1);
  lock_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (TMR_W'(LOCK_CYCLES - 1)),
    .en       (state_q == LOCKOUT),
    .done     (tmr_done)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    fail_d = fail_q;
    pat_d = pat_q;
    tmr_load = 1'b0;
    if (state_q == LOCKOUT) begin
      if (tmr_done) begin
        state_d = IDLE;
        fail_d = '0;
      end
    end else if (cfg_load) begin
      pat_d = cfg_pattern;
      idx_d = '0;
      fail_d = '0;
      state_d = IDLE;
    end else if (state_q == OPEN) begin
      state_d = IDLE;
    end else if (sym_valid) begin
      if (sym == cur_sym) begin
        idx_d = (idx_q == IDX_W'(SEQ_LEN - 1)) ? '0 : idx_q + IDX_W'(1);
        fail_d = (idx_q == IDX_W'(SEQ_LEN - 1)) ? '0 : fail_q;
        state_d = (idx_q == IDX_W'(SEQ_LEN - 1)) ? OPEN : IDLE;
      end else if (fail_inc == FAIL_W'(MAX_FAILS)) begin
        fail_d = fail_inc;
        idx_d = '0;
        state_d = LOCKOUT;
        tmr_load = 1'b1;
      end else begin
        // restart, letting the offending symbol start a fresh attempt
        fail_d = fail_inc;
        idx_d = (sym == first_sym) ? IDX_W'(1) : '0;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q <= '0;
      fail_q <= '0;
      pat_q <= PATTERN;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      fail_q <= fail_d;
      pat_q <= pat_d;
    end
  assign P1 = (state_q == OPEN);
  assign P2 = (state_q == LOCKOUT);
  assign progress = (state_q == IDLE) ? PROG_W'(idx_q) : '0;
endmodule

// File: tb/tb_seq_lock_moore.sv
// tb_seq_lock_moore: directed scoreboard bench for the default-parameter sequence lock
module tb_seq_lock_moore;
  logic clk = 1'b0, rst_n = 1'b0, sym_valid = 1'b0, cfg_load = 1'b0;
  logic [1:0] sym = '0;
  logic [7:0] cfg_pattern = '0;
  logic P1, P2;
  logic [2:0] progress;
  typedef struct packed {logic p1; logic p2; logic [2:0] prog;} exp_t;
  exp_t exp_q[$];
  string tag_q[$];
  int n_chk = 0, n_pass = 0, n_fail = 0;

  seq_lock_moore dut (
    .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym(sym),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
    .P1(P1), .P2(P2), .progress(progress)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got, input logic [2:0] want);
    n_chk++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  task automatic step(input logic rn, input logic v, input logic [1:0] s, input logic cl,
                      input logic [7:0] cp, input logic ep1, input logic ep2,
                      input logic [2:0] epr, input string tag);
    exp_t e;
    string t;
    rst_n = rn; sym_valid = v; sym = s; cfg_load = cl; cfg_pattern = cp;
    exp_q.push_back('{p1: ep1, p2: ep2, prog: epr});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".P1"}, {2'b0, P1}, {2'b0, e.p1});
    chk({t, ".P2"}, {2'b0, P2}, {2'b0, e.p2});
    chk({t, ".prog"}, progress, e.prog);
  endtask

  task automatic sy(input logic [1:0] s, input logic ep1, input logic ep2, input logic [2:0] epr, input string tag);
    step(1'b1, 1'b1, s, 1'b0, 8'h00, ep1, ep2, epr, tag);
  endtask

  task automatic gap(input logic ep1, input logic ep2, input logic [2:0] epr, input string tag);
    step(1'b1, 1'b0, 2'b00, 1'b0, 8'h00, ep1, ep2, epr, tag);
  endtask

  task automatic rst(input string tag);
    step(1'b0, 1'b1, 2'b10, 1'b1, 8'hFF, 1'b0, 1'b0, 3'd0, tag);
  endtask

  task automatic open_default(input string tag);
    sy(2'b10, 0, 0, 3'd1, {tag, ".s0"});
    sy(2'b01, 0, 0, 3'd2, {tag, ".s1"});
    sy(2'b11, 0, 0, 3'd3, {tag, ".s2"});
    sy(2'b00, 1, 0, 3'd0, {tag, ".s3"});
    gap(0, 0, 3'd0, {tag, ".after"});
  endtask

  initial begin
    rst("reset0");
    rst("reset1");
    gap(0, 0, 3'd0, "reset_idle");
    open_default("basic");
    // mismatch at idx 2 restarts with the offending symbol as a fresh first symbol
    sy(2'b10, 0, 0, 3'd1, "mm.s0");
    sy(2'b01, 0, 0, 3'd2, "mm.s1");
    sy(2'b10, 0, 0, 3'd1, "mm.bad");
    sy(2'b01, 0, 0, 3'd2, "mm.r1");
    sy(2'b11, 0, 0, 3'd3, "mm.r2");
    sy(2'b00, 1, 0, 3'd0, "mm.open");
    gap(0, 0, 3'd0, "mm.after");
    // three fresh failures lock only if the earlier failure was cleared by the open
    sy(2'b11, 0, 0, 3'd0, "lk.f1");
    sy(2'b11, 0, 0, 3'd0, "lk.f2");
    sy(2'b11, 0, 1, 3'd0, "lk.f3");
    sy(2'b10, 0, 1, 3'd0, "lk.ign0");
    sy(2'b01, 0, 1, 3'd0, "lk.ign1");
    sy(2'b11, 0, 1, 3'd0, "lk.ign2");
    sy(2'b00, 0, 1, 3'd0, "lk.ign3");
    step(1'b1, 1'b0, 2'b00, 1'b1, 8'h1B, 0, 1, 3'd0, "lk.cfg_ign");
    for (int i = 0; i < 10; i++) gap(0, 1, 3'd0, $sformatf("lk.hold%0d", i));
    gap(0, 0, 3'd0, "lk.release");
    open_default("post_lock");
    // cfg_load wins over a same-cycle symbol
    step(1'b1, 1'b1, 2'b10, 1'b1, 8'h1B, 0, 0, 3'd0, "cfg.load");
    sy(2'b11, 0, 0, 3'd1, "cfg.s0");
    sy(2'b10, 0, 0, 3'd2, "cfg.s1");
    sy(2'b01, 0, 0, 3'd3, "cfg.s2");
    sy(2'b00, 1, 0, 3'd0, "cfg.s3");
    gap(0, 0, 3'd0, "cfg.after");
    sy(2'b10, 0, 0, 3'd0, "cfg.old0");
    sy(2'b01, 0, 0, 3'd0, "cfg.old1");
    // reset restores the default pattern and clears the two pending failures
    rst("rst.a");
    sy(2'b10, 0, 0, 3'd1, "rst.s0");
    sy(2'b01, 0, 0, 3'd2, "rst.s1");
    rst("rst.mid");
    open_default("rst.full");
    sy(2'b00, 0, 0, 3'd0, "rst.f1");
    sy(2'b00, 0, 0, 3'd0, "rst.f2");
    sy(2'b00, 0, 1, 3'd0, "rst.f3");
    gap(0, 1, 3'd0, "rst.lk0");
    gap(0, 1, 3'd0, "rst.lk1");
    rst("rst.lock");
    gap(0, 0, 3'd0, "rst.lk_after");
    // long gaps between symbols do not change the result
    sy(2'b10, 0, 0, 3'd1, "gap.s0");
    for (int i = 0; i < 5; i++) gap(0, 0, 3'd1, $sformatf("gap.a%0d", i));
    sy(2'b01, 0, 0, 3'd2, "gap.s1");
    for (int i = 0; i < 5; i++) gap(0, 0, 3'd2, $sformatf("gap.b%0d", i));
    sy(2'b11, 0, 0, 3'd3, "gap.s2");
    for (int i = 0; i < 5; i++) gap(0, 0, 3'd3, $sformatf("gap.c%0d", i));
    sy(2'b00, 1, 0, 3'd0, "gap.s3");
    gap(0, 0, 3'd0, "gap.after");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
